// File: rtl/fetch_pc_ctrl_pkg.sv
// ============================================================================
// Module   : fetch_pc_ctrl_pkg
// Brief    : Shared widths, reset PC, increment and FSM state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pc_ctrl_pkg;

  localparam int             ADDR_W   = 16;
  localparam logic [15:0]    RESET_PC = 16'h0000;
  localparam int             PC_INC   = 2;

  localparam logic [1:0]     ST_FETCH  = 2'b00;
  localparam logic [1:0]     ST_WAIT   = 2'b01;
  localparam logic [1:0]     ST_HALTED = 2'b10;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_ctrl_pc_reg.sv
// ============================================================================
// Module   : pc_reg
// Brief    : W-bit register with synchronous reset-to-value and load enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_reg #(
  parameter int           W       = fetch_pc_ctrl_pkg::ADDR_W,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
// ============================================================================
// Module   : fetch_pc_ctrl
// Brief    : Fetch PC controller with redirect squash, imem handshake, HALT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_pc_ctrl #(
  parameter int                ADDR_W   = fetch_pc_ctrl_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = fetch_pc_ctrl_pkg::RESET_PC,
  parameter int                PC_INC   = fetch_pc_ctrl_pkg::PC_INC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              brchcnd,
  input  logic [ADDR_W-1:0] brch_target,
  input  logic              jr_valid,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              halt,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic              fetch_valid,
  output logic              halted
);

  import fetch_pc_ctrl_pkg::*;

  logic [1:0]        state;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_tgt;
  logic              active;
  logic              done;
  logic              redir;
  logic [ADDR_W-1:0] target;
  logic              halt_take;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_next;
  logic              pend_load;

  pc_reg #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_next),
    .q    (pc)
  );

  pc_reg #(.W(ADDR_W), .RST_VAL('0)) u_pend_tgt (
    .clk  (clk),
    .rst  (rst),
    .load (pend_load),
    .d    (target),
    .q    (pend_tgt)
  );

  always_comb begin
    active      = (state != ST_HALTED);
    imem_req    = ~rst & active;
    imem_addr   = pc;
    pc_plus2    = pc + ADDR_W'(PC_INC);
    halted      = ~rst & (state == ST_HALTED);
    done        = imem_req & imem_ready;
    redir       = jr_valid | brchcnd;
    target      = jr_valid ? jr_target : brch_target;
    // A halt seen alongside a redirect (live or pending) is on the wrong path.
    halt_take   = imem_req & halt & ~redir & ~pend_v;
    fetch_valid = done & ~halt_take & ~pend_v & ~redir & ~stall;
    // Only the oldest redirect is remembered while the fetch is outstanding.
    pend_load   = imem_req & ~done & ~halt_take & redir & ~pend_v;
    pc_load     = 1'b0;
    pc_next     = pc_plus2;
    if (done && !halt_take) begin
      pc_load = 1'b1;
      if (pend_v) begin
        pc_next = pend_tgt;
      end else if (redir) begin
        pc_next = target;
      end else if (stall) begin
        pc_next = pc;
      end else begin
        pc_next = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_FETCH;
      pend_v <= 1'b0;
    end else if (halt_take) begin
      state  <= ST_HALTED;
    end else if (done) begin
      state  <= ST_FETCH;
      pend_v <= 1'b0;
    end else if (active) begin
      state  <= ST_WAIT;
      if (pend_load) begin
        pend_v <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
